spi_frame_slave: RTL and testbench

- Second-generation SPI target for the orbtrace host link. Receives one RX_BITS command frame after CS assertion, then streams TX_BITS packets back-to-back until CS deasserts.
- Runs entirely in the system clock domain. SCK, MOSI and CS are oversampled through synchronisers, with no logic clocked by SCK.
- Generalised over frame widths and all four SPI modes.
- Replaces toggle signalling with valid/ready and pulse interfaces, and adds underrun reporting.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_edge_sync.sv | 32 +++
 rtl/spi_frame_slave.sv | 152 +++++++++++++++
 tb/tb_spi_frame_slave.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame target: FSM states, default
// frame widths and the SPI-mode to sample-edge mapping.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TX   = 2'd2
  } spi_state_e;

  localparam int RX_BITS_DEF = 32;
  localparam int TX_BITS_DEF = 128;

  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling.
  function automatic bit sample_on_rise(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronised level.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_frame_slave.sv
// Oversampled SPI target: one RX_BITS command frame after CS falls, then
// back-to-back TX_BITS packets on MISO until CS rises.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int RX_BITS     = RX_BITS_DEF,
  parameter int TX_BITS     = TX_BITS_DEF,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_FILL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  input  logic               spi_cs_n,
  output logic               spi_miso,
  input  logic [TX_BITS-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic               underrun,
  output logic               busy
);

  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam int RXW = $clog2(RX_BITS);
  localparam int TXW = $clog2(TX_BITS);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_BITS - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_BITS - 1);

  logic w_unused_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_cs_n, w_cs_rise, w_cs_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
    .clk(clk), .rst(rst), .i_async(spi_sck),
    .o_level(w_unused_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_async(spi_mosi),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_async(spi_cs_n),
    .o_level(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_state_e         r_state;
  logic [RX_BITS-2:0] r_rx_shift;
  logic [RX_BITS-1:0] r_rx_data;
  logic [RXW-1:0]     r_rx_cnt;
  logic               r_rx_valid;
  logic [TX_BITS-1:0] r_tx_shift;
  logic [TXW-1:0]     r_tx_cnt;
  logic               r_load_pend;
  logic               r_miso;
  logic               r_busy;

  logic               w_sample, w_shift, w_load;
  logic [RX_BITS-1:0] w_rx_next;
  logic [TX_BITS-1:0] w_tx_word;

  assign w_sample  = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
  assign w_shift   = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
  assign w_rx_next = {r_rx_shift, w_mosi};
  assign w_tx_word = tx_valid ? tx_data : {TX_BITS{IDLE_FILL}};

  // The packet slot is offered combinationally so tx_valid/tx_data are
  // captured on the same edge that tx_ready is seen; CS release takes priority.
  assign w_load = ~rst & (r_state == ST_TX) & r_load_pend & w_shift & ~w_cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_cnt    <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_shift  <= '0;
      r_tx_cnt    <= '0;
      r_load_pend <= 1'b0;
      r_miso      <= IDLE_FILL;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_busy     <= ~w_cs_n;
      if (w_cs_rise) begin
        r_state     <= ST_IDLE;
        r_miso      <= IDLE_FILL;
        r_load_pend <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso <= IDLE_FILL;
            if (w_cs_fall) begin
              r_state  <= ST_RX;
              r_rx_cnt <= '0;
            end
          end
          ST_RX: begin
            r_miso <= IDLE_FILL;
            if (w_sample) begin
              r_rx_shift <= w_rx_next[RX_BITS-2:0];
              r_rx_cnt   <= r_rx_cnt + 1'b1;
              if (r_rx_cnt == RX_LAST) begin
                r_rx_data   <= w_rx_next;
                r_rx_valid  <= 1'b1;
                r_rx_cnt    <= '0;
                r_state     <= ST_TX;
                r_tx_cnt    <= '0;
                r_load_pend <= 1'b1;
              end
            end
          end
          ST_TX: begin
            if (w_load) begin
              r_miso      <= w_tx_word[TX_BITS-1];
              r_tx_shift  <= {w_tx_word[TX_BITS-2:0], IDLE_FILL};
              r_load_pend <= 1'b0;
            end else if (w_shift) begin
              r_miso     <= r_tx_shift[TX_BITS-1];
              r_tx_shift <= {r_tx_shift[TX_BITS-2:0], IDLE_FILL};
            end
            // Word boundary is counted on sample edges; the next shift edge reloads.
            if (w_sample) begin
              if (r_tx_cnt == TX_LAST) begin
                r_tx_cnt    <= '0;
                r_load_pend <= 1'b1;
              end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_ready = w_load;
  assign underrun = w_load & ~tx_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Scoreboard bench: four targets (all SPI modes) driven by a bit-level SPI
// controller model; expected frames and MISO words are queued up front.
module tb_spi_frame_slave;

  localparam int H = 8;  // SCK half period in clk cycles

  typedef struct packed { logic v; logic [127:0] d; } sup_t;
  typedef struct packed { logic [1:0] k; logic [31:0] d; } rxe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sck[4], mosi[4], cs_n[4], tx_valid[4];
  logic [127:0] txd[4];
  logic         miso[4], tx_ready[4], rx_valid[4], underrun[4], busy[4];
  logic [31:0]  rxd[4];

  int checks = 0;
  int errors = 0;
  int act = 0;
  int trc[4] = '{default: 0};
  int urc[4] = '{default: 0};

  sup_t         sup_q[$];
  rxe_t         exp_rx[$];
  logic [127:0] exp_mi[$];
  logic [127:0] obs_mi[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RB = (g == 0) ? 32 : 16;
    localparam int TB = (g == 0) ? 128 : 64;
    localparam bit PL = ((g >> 1) & 1) == 1;
    localparam bit PH = (g & 1) == 1;
    logic [RB-1:0] w_rx;
    logic [TB-1:0] w_txd;
    assign w_txd  = txd[g][TB-1:0];
    assign rxd[g] = 32'(w_rx);
    spi_frame_slave #(
      .RX_BITS(RB), .TX_BITS(TB), .CPOL(PL), .CPHA(PH),
      .SYNC_STAGES(2), .IDLE_FILL(1'b1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .spi_sck(sck[g]), .spi_mosi(mosi[g]), .spi_cs_n(cs_n[g]),
      .spi_miso(miso[g]),
      .tx_data(w_txd), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(w_rx), .rx_valid(rx_valid[g]),
      .underrun(underrun[g]), .busy(busy[g])
    );
  end

  function automatic int rbits(input int k); return (k == 0) ? 32 : 16; endfunction
  function automatic int tbits(input int k); return (k == 0) ? 128 : 64; endfunction
  function automatic logic [127:0] ones(input int n);
    return (n >= 128) ? {128{1'b1}} : ((128'd1 << n) - 128'd1);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: pulse counters, rx_valid scoreboard, MISO word scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (tx_ready[k] === 1'b1) trc[k]++;
        if (underrun[k] === 1'b1) urc[k]++;
        if (rx_valid[k] === 1'b1) begin
          if (exp_rx.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_unexpected: inst %0d got %h want no frame", k, rxd[k]);
          end else begin
            rxe_t e;
            e = exp_rx.pop_front();
            chk("rx_data", {94'd0, 2'(k), rxd[k]}, {94'd0, e.k, e.d});
          end
        end
      end
      while (obs_mi.size() > 0) begin
        logic [127:0] o;
        o = obs_mi.pop_front();
        if (exp_mi.size() == 0) begin
          checks++; errors++;
          $display("FAIL miso_unexpected: got %h want no word", o);
        end else begin
          chk("miso_word", o, exp_mi.pop_front());
        end
      end
    end
  end

  // Packet source: presents the queue head to the active target and retires it
  // one cycle after tx_ready was seen, i.e. after the DUT captured it.
  initial begin
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && sup_q.size() > 0) void'(sup_q.pop_front());
      pend = 1'b0;
      if (tx_ready[act] === 1'b1) pend = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tx_valid[k] = (k == act && sup_q.size() > 0) ? sup_q[0].v : 1'b0;
        txd[k]      = (k == act && sup_q.size() > 0) ? sup_q[0].d : 128'd0;
      end
    end
  end

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  // One CS-framed transfer; sup_q must already hold the packet schedule.
  task automatic scen(input int k, input logic [31:0] cmd, input int nbits, input int rst_at);
    int rb, tb, nw, nu, t0, u0, total, wb;
    bit cpol, cpha, cs_done;
    logic [127:0] rm, tm, w;
    rb = rbits(k); tb = tbits(k);
    cpol = k[1]; cpha = k[0];
    rm = ones(rb); tm = ones(tb);
    nw = (nbits == rb) ? sup_q.size() : 0;
    nu = 0; t0 = trc[k]; u0 = urc[k];
    act = k;
    if (nbits == rb) begin
      exp_rx.push_back('{k: 2'(k), d: cmd & rm[31:0]});
      exp_mi.push_back(rm);
      if (rst_at < 0) begin
        foreach (sup_q[i]) begin
          exp_mi.push_back(sup_q[i].v ? (sup_q[i].d & tm) : tm);
          if (!sup_q[i].v) nu++;
        end
      end
    end
    total = nbits + nw * tb;
    cs_done = 1'b0; w = '0; wb = 0;
    cs_n[k] = 1'b0;
    half();
    for (int b = 0; b < total; b++) begin
      logic mo, mi;
      if (b == rst_at) begin
        chk("pre_rst_miso", 128'(miso[k]), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_miso", 128'(miso[k]), 128'd1);
        chk("rst_busy", 128'(busy[k]), 128'd0);
        chk("rst_pulses", {125'd0, tx_ready[k], underrun[k], rx_valid[k]}, 128'd0);
        chk("rst_rx_data", 128'(rxd[k]), 128'd0);
        rst = 1'b0;
        break;
      end
      if (b == rb / 2) chk("busy_active", 128'(busy[k]), 128'd1);
      mo = (b < rb) ? cmd[rb-1-b] : 1'($urandom);
      if (!cpha) begin
        mosi[k] = mo;
        half();
        sck[k] = ~cpol;
        mi = miso[k];
        half();
        sck[k] = cpol;
        // Release CS together with the final trailing edge so no extra slot opens.
        if (b == total - 1) begin cs_n[k] = 1'b1; cs_done = 1'b1; end
      end else begin
        sck[k] = ~cpol;
        mosi[k] = mo;
        half();
        sck[k] = cpol;
        mi = miso[k];
        half();
      end
      w = {w[126:0], mi};
      wb++;
      if ((b < rb && wb == rb) || (b >= rb && wb == tb)) begin
        obs_mi.push_back(w);
        w = '0; wb = 0;
      end
    end
    if (!cs_done) begin
      half();
      cs_n[k] = 1'b1;
    end
    repeat (4 * H) @(negedge clk);
    if (rst_at < 0) begin
      chk("tx_ready_cnt", 128'(trc[k] - t0), 128'(nw));
      chk("underrun_cnt", 128'(urc[k] - u0), 128'(nu));
    end
    chk("idle_miso", 128'(miso[k]), 128'd1);
    chk("idle_busy", 128'(busy[k]), 128'd0);
    sup_q.delete();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    for (int k = 0; k < 4; k++) begin
      sck[k]  = k[1];
      mosi[k] = 1'b0;
      cs_n[k] = 1'b1;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_miso", 128'(miso[k]), 128'd1);
      chk("reset_rx_data", 128'(rxd[k]), 128'd0);
      chk("reset_flags", {124'd0, busy[k], rx_valid[k], tx_ready[k], underrun[k]}, 128'd0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      sup_q.push_back('{v: 1'b1, d: d});
      sup_q.push_back('{v: 1'b1, d: d});
      scen(k, 32'hDEADBEEF, rbits(k), -1);

      sup_q.push_back('{v: 1'b1, d: d});
      sup_q.push_back('{v: 1'b0, d: rnd128()});
      sup_q.push_back('{v: 1'b1, d: ~d});
      scen(k, $urandom, rbits(k), -1);

      for (int i = 0; i < 2; i++) sup_q.push_back('{v: ($urandom_range(3) != 0), d: rnd128()});
      scen(k, $urandom, rbits(k), -1);
    end

    // Aborted command frame, then a clean one.
    scen(0, $urandom, 20, -1);
    sup_q.push_back('{v: 1'b1, d: rnd128()});
    scen(0, 32'h12345678, 32, -1);

    // Reset in the middle of TX bit 40, then a normal frame.
    sup_q.push_back('{v: 1'b1, d: 128'd0});
    scen(0, $urandom, 32, 32 + 40);
    sup_q.push_back('{v: 1'b1, d: d});
    scen(0, $urandom, 32, -1);

    repeat (20) @(negedge clk);
    chk("rx_queue_drained", 128'(exp_rx.size()), 128'd0);
    chk("miso_queue_drained", 128'(exp_mi.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
